// File: rtl/universal_shift_register.sv
// -----------------------------------------------------------------------------
// universal_shift_register
//
// Parallel-load shift register with single-step shifts and counted bursts.
// Shifts go right (toward the LSB) or left, and either rotate or fill from
// SerI. A burst of N shifts is started with Start; Busy is high while it
// runs, and Done pulses for one cycle when it completes.
//
// Parameters:
//   WIDTH  register width in bits (minimum 2)
//   CNTW   width of the burst-length input N
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset
//   L      parallel load request (highest priority, also aborts a burst)
//   Shift  single-step shift request (idle only)
//   Dir    shift direction: 0 = right, 1 = left
//   Rot    1 = rotate, 0 = fill from SerI
//   SerI   serial fill bit
//   D      parallel load data
//   Start  begin a burst of N shifts (idle only)
//   N      burst length, sampled with Start
//   Q      register contents
//   SerO   bit expelled by the most recent shift
//   Busy   burst in progress
//   Done   one-cycle pulse at burst completion
//   Par    XOR of all bits of Q (only when USR_PARITY_EN is defined)
//
// Build option: define USR_PARITY_EN to add the Par output.
// -----------------------------------------------------------------------------
module universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             L,
    input  logic             Shift,
    input  logic             Dir,
    input  logic             Rot,
    input  logic             SerI,
    input  logic [WIDTH-1:0] D,
    input  logic             Start,
    input  logic [CNTW-1:0]  N,
    output logic [WIDTH-1:0] Q,
    output logic             SerO,
    output logic             Busy,
    output logic             Done
`ifdef USR_PARITY_EN
    ,
    output logic             Par
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [CNTW-1:0]   remaining, remaining_next;
    logic [WIDTH-1:0]  q_next;
    logic              sero_next;
    logic              done_next;
    logic              do_shift;
    logic              fill;

    // Next-state and datapath decode.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves one unassigned, which would infer a latch.
        state_next     = state;
        remaining_next = remaining;
        q_next         = Q;
        sero_next      = SerO;
        done_next      = 1'b0;
        do_shift       = 1'b0;
        fill           = 1'b0;

        unique case (state)
            IDLE: begin
                if (L) begin
                    q_next = D;
                end else if (Start) begin
                    if (N != '0) begin
                        // The Start edge itself only arms the burst.
                        state_next     = BURST;
                        remaining_next = N;
                    end else begin
                        done_next = 1'b1;
                    end
                end else if (Shift) begin
                    do_shift = 1'b1;
                end
            end
            BURST: begin
                if (L) begin
                    // Abort: load wins, no Done for the cut-short burst.
                    q_next         = D;
                    state_next     = IDLE;
                    remaining_next = '0;
                end else begin
                    do_shift       = 1'b1;
                    remaining_next = remaining - CNTW'(1);
                    if (remaining == CNTW'(1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (do_shift) begin
            if (Dir) begin
                fill      = Rot ? Q[WIDTH-1] : SerI;
                q_next    = {Q[WIDTH-2:0], fill};
                sero_next = Q[WIDTH-1];
            end else begin
                fill      = Rot ? Q[0] : SerI;
                q_next    = {fill, Q[WIDTH-1:1]};
                sero_next = Q[0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            Q         <= '0;
            SerO      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from
            // the same pre-edge values, as real flops do.
            state     <= state_next;
            remaining <= remaining_next;
            Q         <= q_next;
            SerO      <= sero_next;
            Done      <= done_next;
        end
    end

    assign Busy = (state == BURST);

`ifdef USR_PARITY_EN
    assign Par = ^Q;
`endif

endmodule
